// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_decode
//  Description : Instruction fetch and decode stage. Drives the PC into the
//                instruction ROM, latches the returned word into the
//                instruction register, and splits it into class, opcode,
//                register and literal fields. Issues each decoded instruction
//                to the datapath with a valid/ready handshake, then steps the
//                PC or redirects it for a jump.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - asynchronous active-low reset
//                run        - fetch enable (0 holds in FETCH)
//                pc         - [7:0] instruction ROM address
//                rom_data   - [15:0] ROM word for pc (combinational)
//                dec_valid  - decoded fields valid, held until accepted
//                dec_ready  - datapath accepts the instruction
//                cls        - [1:0] instruction class
//                opcode     - [4:0] operation
//                da/aa/ba   - [2:0] destination / source A / source B
//                imm        - [10:0] zero-extended literal
//                imm_en     - imm is the B operand
//                br_valid   - jump request, used only on the handshake cycle
//                br_target  - [7:0] jump destination
//                halted     - fetch stopped, cleared only by reset
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_decode #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter bit         HALT_ON_NOP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [7:0]  pc,
    input  logic [15:0] rom_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [1:0]  cls,
    output logic [4:0]  opcode,
    output logic [2:0]  da,
    output logic [2:0]  aa,
    output logic [2:0]  ba,
    output logic [10:0] imm,
    output logic        imm_en,
    input  logic        br_valid,
    input  logic [7:0]  br_target,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_pc;
    logic [7:0]  w_pc_nxt;
    logic [15:0] r_ir;
    logic [15:0] w_ir_nxt;
    logic        w_is_nop;

    // An all-zero word is the ROM's unprogrammed value; optionally it stops fetch.
    assign w_is_nop = (HALT_ON_NOP == 1'b1) && (rom_data == 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        case (r_state)
            S_FETCH: begin
                if (run) begin
                    if (w_is_nop) begin
                        // IR keeps the previous word; PC freezes at the NOP address.
                        w_state_nxt = S_HALT;
                    end else begin
                        w_ir_nxt    = rom_data;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (dec_ready) begin
                    // Redirect decision is taken only on the accepting cycle.
                    w_pc_nxt    = br_valid ? br_target : (r_pc + 8'd1);
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    assign pc        = r_pc;
    assign dec_valid = (r_state == S_ISSUE);
    assign halted    = (r_state == S_HALT);
    assign cls       = r_ir[15:14];

    // Field extraction straight from the instruction register.
    always_comb begin
        opcode = 5'd0;
        da     = 3'd0;
        aa     = 3'd0;
        ba     = 3'd0;
        imm    = 11'd0;
        imm_en = 1'b0;
        case (r_ir[15:14])
            2'b00: begin
                // Immediate ALU: destination doubles as source A.
                opcode = {2'b00, r_ir[13:11]};
                da     = r_ir[10:8];
                aa     = r_ir[10:8];
                imm    = {3'b000, r_ir[7:0]};
                imm_en = 1'b1;
            end
            2'b01: begin
                opcode = r_ir[13:9];
                da     = r_ir[8:6];
                aa     = r_ir[5:3];
                ba     = r_ir[2:0];
            end
            2'b10: begin
                if (r_ir[13]) begin
                    opcode = {3'b100, r_ir[12:11]};
                    da     = r_ir[10:8];
                    aa     = r_ir[10:8];
                    imm    = {3'b000, r_ir[7:0]};
                    imm_en = 1'b1;
                end else begin
                    opcode = {1'b0, r_ir[12:9]};
                    da     = r_ir[8:6];
                    aa     = r_ir[5:3];
                    ba     = r_ir[2:0];
                end
            end
            default: begin
                // Load-long: the full 11-bit literal goes to the destination.
                da     = r_ir[13:11];
                imm    = r_ir[10:0];
                imm_en = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_decode
//  Description : Self-checking bench for instr_fetch_decode with a ROM model
//                and an expected-instruction queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_decode;

    typedef struct packed {
        logic [1:0]  cls;
        logic [4:0]  opcode;
        logic [2:0]  da;
        logic [2:0]  aa;
        logic [2:0]  ba;
        logic [10:0] imm;
        logic        imm_en;
        logic [7:0]  pc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  pc;
    logic [15:0] rom_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [1:0]  cls;
    logic [4:0]  opcode;
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic [10:0] imm;
    logic        imm_en;
    logic        br_valid;
    logic [7:0]  br_target;
    logic        halted;

    logic [15:0] rom [256];
    exp_t        sb [$];
    int          n_checks;
    int          n_fail;

    assign rom_data = rom[pc];

    instr_fetch_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .pc        (pc),
        .rom_data  (rom_data),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .cls       (cls),
        .opcode    (opcode),
        .da        (da),
        .aa        (aa),
        .ba        (ba),
        .imm       (imm),
        .imm_en    (imm_en),
        .br_valid  (br_valid),
        .br_target (br_target),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] c, input logic [4:0] op, input logic [2:0] d,
                                input logic [2:0] a, input logic [2:0] b, input logic [10:0] im,
                                input logic ie, input logic [7:0] p);
        exp_t e;
        e.cls = c; e.opcode = op; e.da = d; e.aa = a; e.ba = b;
        e.imm = im; e.imm_en = ie; e.pc = p;
        return e;
    endfunction

    // One instruction: expect it to be issued, hold it for 'hold' cycles, then accept.
    task automatic do_instr(input string tag, input exp_t e, input int hold, input logic br,
                            input logic [7:0] tgt, input logic [7:0] next_pc);
        exp_t got;
        int   n;
        sb.push_back(e);
        dec_ready = 1'b0;
        run       = 1'b1;
        n = 0;
        while (dec_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'd0, dec_valid}, 32'd1);
        got = sb.pop_front();
        check({tag, "_cls"},    {30'd0, cls},    {30'd0, got.cls});
        check({tag, "_opcode"}, {27'd0, opcode}, {27'd0, got.opcode});
        check({tag, "_da"},     {29'd0, da},     {29'd0, got.da});
        check({tag, "_aa"},     {29'd0, aa},     {29'd0, got.aa});
        check({tag, "_ba"},     {29'd0, ba},     {29'd0, got.ba});
        check({tag, "_imm"},    {21'd0, imm},    {21'd0, got.imm});
        check({tag, "_imm_en"}, {31'd0, imm_en}, {31'd0, got.imm_en});
        check({tag, "_pc"},     {24'd0, pc},     {24'd0, got.pc});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"},  {31'd0, dec_valid}, 32'd1);
            check({tag, "_hold_pc"},     {24'd0, pc},        {24'd0, got.pc});
            check({tag, "_hold_opcode"}, {27'd0, opcode},    {27'd0, got.opcode});
        end
        dec_ready = 1'b1;
        br_valid  = br;
        br_target = tgt;
        @(posedge clk);
        #1;
        dec_ready = 1'b0;
        br_valid  = 1'b0;
        check({tag, "_next_pc"},    {24'd0, pc},        {24'd0, next_pc});
        check({tag, "_valid_drop"}, {31'd0, dec_valid}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        run       = 1'b0;
        dec_ready = 1'b0;
        br_valid  = 1'b0;
        br_target = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0101;
        rom[8'h00] = 16'h0901;
        rom[8'h01] = 16'h59CA;
        rom[8'h02] = 16'hD801;
        rom[8'h03] = 16'hA101;
        rom[8'h04] = 16'h8E53;
        rom[8'h1B] = 16'h0901;
        rom[8'hFF] = 16'h59CA;
        rom[8'h1D] = 16'h0000;

        // Reset state
        #22;
        check("rst_pc",     {24'd0, pc},     32'h00);
        check("rst_valid",  {31'd0, dec_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cls",    {30'd0, cls},    32'd0);
        check("rst_opcode", {27'd0, opcode}, 32'd0);
        check("rst_da",     {29'd0, da},     32'd0);
        check("rst_imm",    {21'd0, imm},    32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;

        // Immediate ALU, accepted at once: pc=1 two clocks after release
        do_instr("imm_alu", mk(2'b00, 5'd1, 3'd1, 3'd1, 3'd0, 11'd1, 1'b1, 8'h00), 0, 1'b0, 8'h00, 8'h01);
        // Register ALU with three stall cycles
        do_instr("reg_alu", mk(2'b01, 5'b01100, 3'd7, 3'd1, 3'd2, 11'd0, 1'b0, 8'h01), 3, 1'b0, 8'h00, 8'h02);
        // Load-long
        do_instr("ld_long", mk(2'b11, 5'd0, 3'd3, 3'd0, 3'd0, 11'd1, 1'b1, 8'h02), 0, 1'b0, 8'h00, 8'h03);
        // Memory-immediate: opcode = {3'b100, ir[12:11]} with ir[12:11]=00
        do_instr("mem_imm", mk(2'b10, 5'b10000, 3'd1, 3'd1, 3'd0, 11'd1, 1'b1, 8'h03), 0, 1'b0, 8'h00, 8'h04);
        // Memory/branch register form, taken jump on the handshake
        do_instr("mem_reg", mk(2'b10, 5'b00111, 3'd1, 3'd2, 3'd3, 11'd0, 1'b0, 8'h04), 1, 1'b1, 8'h1B, 8'h1B);

        // Jump request while in FETCH is ignored
        run       = 1'b0;
        br_valid  = 1'b1;
        br_target = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        br_valid = 1'b0;
        check("fetch_br_pc",    {24'd0, pc},        32'h1B);
        check("fetch_br_valid", {31'd0, dec_valid}, 32'd0);

        // Jump to 0xFF, then sequential wrap to 0x00, then jump to the NOP
        do_instr("to_ff",  mk(2'b00, 5'd1, 3'd1, 3'd1, 3'd0, 11'd1, 1'b1, 8'h1B), 0, 1'b1, 8'hFF, 8'hFF);
        do_instr("wrap",   mk(2'b01, 5'b01100, 3'd7, 3'd1, 3'd2, 11'd0, 1'b0, 8'hFF), 0, 1'b0, 8'h00, 8'h00);
        do_instr("to_nop", mk(2'b00, 5'd1, 3'd1, 3'd1, 3'd0, 11'd1, 1'b1, 8'h00), 0, 1'b1, 8'h1D, 8'h1D);

        // NOP at 0x1D halts fetch
        @(posedge clk);
        #1;
        check("halt_flag",  {31'd0, halted},    32'd1);
        check("halt_pc",    {24'd0, pc},        32'h1D);
        check("halt_valid", {31'd0, dec_valid}, 32'd0);
        br_valid  = 1'b1;
        br_target = 8'h40;
        dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        br_valid  = 1'b0;
        dec_ready = 1'b0;
        check("halt_hold_flag",  {31'd0, halted},    32'd1);
        check("halt_hold_pc",    {24'd0, pc},        32'h1D);
        check("halt_hold_valid", {31'd0, dec_valid}, 32'd0);

        // Reset clears the halt; then reset asynchronously in the middle of ISSUE
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        check("rearm_halted", {31'd0, halted}, 32'd0);
        rst_n = 1'b1;
        do_instr("rearm", mk(2'b00, 5'd1, 3'd1, 3'd1, 3'd0, 11'd1, 1'b1, 8'h00), 0, 1'b0, 8'h00, 8'h01);
        @(posedge clk);
        #1;
        check("mid_issue_valid", {31'd0, dec_valid}, 32'd1);
        check("mid_issue_cls",   {30'd0, cls},       32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc",     {24'd0, pc},        32'h00);
        check("async_rst_valid",  {31'd0, dec_valid}, 32'd0);
        check("async_rst_halted", {31'd0, halted},    32'd0);
        check("async_rst_cls",    {30'd0, cls},       32'd0);
        check("sb_empty",         sb.size(),          32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
